// File: rtl/qchannel_ctrl_if.sv
// Q-Channel handshake bundle between the controller (master) and the
// clock-gated device (slave).
interface qchannel_ctrl_if;
  logic qreqn;
  logic qacceptn;
  logic qdeny;

  modport master (output qreqn, input qacceptn, input qdeny);
  modport slave  (input qreqn, output qacceptn, output qdeny);
endinterface

// File: rtl/qchannel_ctrl.sv
// Q-Channel low-power controller: idle-window auto quiesce, software stop,
// wake handling and sticky monitoring of device handshake violations.
module qchannel_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            en_i,
  input  logic            sw_stop_i,
  input  logic            wake_i,
  input  logic            bus_active_i,
  qchannel_ctrl_if.master q_if,
  output logic            clk_en_o,
  output logic [2:0]      state_o,
  output logic [7:0]      deny_cnt_o,
  output logic            proto_err_o
);

  // state   | meaning
  // RUN     | device clocked, idle window counting
  // REQUEST | qreqn low, waiting for accept or deny
  // STOPPED | device accepted, clock gated
  // EXIT    | qreqn high, waiting for accept release
  // DENIED  | device refused, waiting for deny release
  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] REQUEST = 3'd1;
  localparam logic [2:0] STOPPED = 3'd2;
  localparam logic [2:0] EXIT    = 3'd3;
  localparam logic [2:0] DENIED  = 3'd4;

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0] acc_sync_q, acc_sync_d;
  logic [SYNC_STAGES-1:0] deny_sync_q, deny_sync_d;
  logic                   qacceptn_s, qdeny_s;

  logic [2:0] state_q, state_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] deny_cnt_q, deny_cnt_d;
  logic       wake_pend_q, wake_pend_d;
  logic       proto_err_q, proto_err_d;
  logic       qreqn_q, qreqn_d;
  logic       clk_en_q, clk_en_d;

  assign acc_sync_d  = {acc_sync_q[SYNC_STAGES-2:0], q_if.qacceptn};
  assign deny_sync_d = {deny_sync_q[SYNC_STAGES-2:0], q_if.qdeny};
  assign qacceptn_s  = acc_sync_q[SYNC_STAGES-1];
  assign qdeny_s     = deny_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = 8'd0;
    wake_pend_d = wake_pend_q;
    proto_err_d = proto_err_q;
    case (state_q)
      RUN: begin
        if (bus_active_i || wake_i) begin
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q < IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
        if (!qacceptn_s || qdeny_s) proto_err_d = 1'b1;
        if (idle_cnt_q == IDLE_MAX && !bus_active_i && !wake_i && (sw_stop_i || en_i))
          state_d = REQUEST;
      end
      REQUEST: begin
        if (wake_i) wake_pend_d = 1'b1;
        // Accept wins over a simultaneous deny; the overlap is flagged.
        if (!qacceptn_s) begin
          state_d = STOPPED;
          if (qdeny_s) proto_err_d = 1'b1;
        end else if (qdeny_s) begin
          state_d = DENIED;
        end
      end
      STOPPED: begin
        if (qdeny_s) proto_err_d = 1'b1;
        if (wake_i || wake_pend_q || (!sw_stop_i && !en_i)) begin
          state_d     = EXIT;
          wake_pend_d = 1'b0;
        end
      end
      EXIT: begin
        if (qdeny_s) proto_err_d = 1'b1;
        if (qacceptn_s) state_d = RUN;
      end
      DENIED: begin
        if (!qacceptn_s) proto_err_d = 1'b1;
        if (!qdeny_s) state_d = RUN;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_comb begin
    deny_cnt_d = deny_cnt_q;
    if (state_d == DENIED && state_q != DENIED && deny_cnt_q != 8'hFF)
      deny_cnt_d = deny_cnt_q + 8'd1;
  end

  // Handshake and gate outputs are registered alongside the state.
  assign qreqn_d  = !(state_d == REQUEST || state_d == STOPPED);
  assign clk_en_d = (state_d != STOPPED);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      acc_sync_q  <= '0;
      deny_sync_q <= '0;
      state_q     <= STOPPED;
      idle_cnt_q  <= 8'd0;
      deny_cnt_q  <= 8'd0;
      wake_pend_q <= 1'b0;
      proto_err_q <= 1'b0;
      qreqn_q     <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      acc_sync_q  <= acc_sync_d;
      deny_sync_q <= deny_sync_d;
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      deny_cnt_q  <= deny_cnt_d;
      wake_pend_q <= wake_pend_d;
      proto_err_q <= proto_err_d;
      qreqn_q     <= qreqn_d;
      clk_en_q    <= clk_en_d;
    end
  end

  assign q_if.qreqn  = qreqn_q;
  assign clk_en_o    = clk_en_q;
  assign state_o     = state_q;
  assign deny_cnt_o  = deny_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_qchannel_ctrl.sv
// Bench for qchannel_ctrl: directed handshake scenarios followed by random
// traffic against a reactive device, all checked against a reference model.
module tb_qchannel_ctrl;
  localparam int IDLE = 16;
  localparam int SYNC = 2;

  localparam int S_RUN  = 0;
  localparam int S_REQ  = 1;
  localparam int S_STOP = 2;
  localparam int S_EXIT = 3;
  localparam int S_DEN  = 4;

  logic       clk;
  logic       rst_n;
  logic       en, sw_stop, wake, bus_active;
  logic       clk_en_w;
  logic [2:0] state_w;
  logic [7:0] deny_cnt_w;
  logic       perr_w;

  qchannel_ctrl_if qif();

  qchannel_ctrl #(.IDLE_CYCLES(IDLE), .SYNC_STAGES(SYNC)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .en_i        (en),
    .sw_stop_i   (sw_stop),
    .wake_i      (wake),
    .bus_active_i(bus_active),
    .q_if        (qif.master),
    .clk_en_o    (clk_en_w),
    .state_o     (state_w),
    .deny_cnt_o  (deny_cnt_w),
    .proto_err_o (perr_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: spec rules applied once per clock edge.
  int m_state, m_quiet, m_deny;
  bit m_wake_pend, m_perr;
  bit m_acc_hist[$];
  bit m_deny_hist[$];

  task automatic model_reset();
    m_state = S_STOP; m_quiet = 0; m_deny = 0; m_wake_pend = 0; m_perr = 0;
    m_acc_hist.delete(); m_deny_hist.delete();
    repeat (SYNC) begin
      m_acc_hist.push_back(1'b0);
      m_deny_hist.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input bit en_v, input bit sw_v, input bit wake_v,
                            input bit act_v, input bit acc_raw, input bit deny_raw);
    bit acc, dny;
    int nxt;
    acc = m_acc_hist.pop_front();
    dny = m_deny_hist.pop_front();
    m_acc_hist.push_back(acc_raw);
    m_deny_hist.push_back(deny_raw);
    nxt = m_state;
    if (m_state == S_RUN) begin
      if (!acc || dny) m_perr = 1;
      if (m_quiet == IDLE && !act_v && !wake_v && (sw_v || en_v)) nxt = S_REQ;
      if (act_v || wake_v) m_quiet = 0;
      else if (m_quiet < IDLE) m_quiet = m_quiet + 1;
    end else begin
      m_quiet = 0;
      if (m_state == S_REQ) begin
        if (wake_v) m_wake_pend = 1;
        if (!acc) begin
          nxt = S_STOP;
          if (dny) m_perr = 1;
        end else if (dny) nxt = S_DEN;
      end else if (m_state == S_STOP) begin
        if (dny) m_perr = 1;
        if (wake_v || m_wake_pend || (!sw_v && !en_v)) nxt = S_EXIT;
      end else if (m_state == S_EXIT) begin
        if (dny) m_perr = 1;
        if (acc) nxt = S_RUN;
      end else begin
        if (!acc) m_perr = 1;
        if (!dny) nxt = S_RUN;
      end
    end
    if (nxt == S_DEN && m_state != S_DEN && m_deny < 255) m_deny = m_deny + 1;
    if (nxt == S_EXIT && m_state != S_EXIT) m_wake_pend = 0;
    m_state = nxt;
  endtask

  task automatic tick();
    bit a, d, e, s, w, b;
    a = qif.qacceptn; d = qif.qdeny; e = en; s = sw_stop; w = wake; b = bus_active;
    @(posedge clk);
    #1;
    model_edge(e, s, w, b, a, d);
    check("state", state_w, m_state);
    check("qreqn", qif.qreqn, (m_state == S_REQ || m_state == S_STOP) ? 0 : 1);
    check("clk_en", clk_en_w, (m_state == S_STOP) ? 0 : 1);
    check("deny_cnt", deny_cnt_w, m_deny);
    check("proto_err", perr_w, m_perr);
  endtask

  task automatic run_until_state(input int tgt, input int max, output int n);
    n = 0;
    while (int'(state_w) != tgt && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_state", state_w, S_STOP);
    check("rst_qreqn", qif.qreqn, 0);
    check("rst_clk_en", clk_en_w, 0);
    check("rst_deny_cnt", deny_cnt_w, 0);
    check("rst_proto_err", perr_w, 0);
    qif.qacceptn = 1'b0; qif.qdeny = 1'b0;
    en = 1'b0; sw_stop = 1'b0; wake = 1'b0; bus_active = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_qreqn", qif.qreqn, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Reactive device: answers requests after a random delay.
  int dev_wait = 0;
  bit allow_viol = 0;

  task automatic device_react();
    if (dev_wait > 0) begin
      dev_wait--;
      return;
    end
    if (!qif.qreqn && qif.qacceptn && !qif.qdeny) begin
      if (allow_viol && $urandom_range(9) == 0) begin
        qif.qacceptn = 1'b0; qif.qdeny = 1'b1;
      end else if ($urandom_range(3) == 0) qif.qdeny = 1'b1;
      else qif.qacceptn = 1'b0;
      dev_wait = $urandom_range(3);
    end else if (qif.qreqn && !qif.qacceptn) begin
      qif.qacceptn = 1'b1;
      dev_wait = $urandom_range(3);
    end else if (qif.qreqn && qif.qdeny) begin
      qif.qdeny = 1'b0;
      dev_wait = $urandom_range(3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    en = 1'b0; sw_stop = 1'b0; wake = 1'b0; bus_active = 1'b0;
    qif.qacceptn = 1'b0; qif.qdeny = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Wake after reset
    tick();
    check("wake_exit_state", state_w, S_EXIT);
    check("wake_exit_qreqn", qif.qreqn, 1);
    check("wake_exit_clk_en", clk_en_w, 1);
    qif.qacceptn = 1'b1;
    run_until_state(S_RUN, 10, n);
    check("exit_to_run_lat", n, 3);

    // Auto quiesce after the idle window
    bus_active = 1'b1;
    tick();
    bus_active = 1'b0; en = 1'b1;
    run_until_state(S_REQ, 40, n);
    check("auto_req_lat", n, 17);
    check("auto_req_qreqn", qif.qreqn, 0);
    qif.qacceptn = 1'b0;
    run_until_state(S_STOP, 10, n);
    check("accept_to_gate", n, 3);
    check("gate_clk_en", clk_en_w, 0);

    en = 1'b0;
    tick();
    qif.qacceptn = 1'b1;
    run_until_state(S_RUN, 10, n);
    check("resume_run", state_w, S_RUN);

    // Deny
    en = 1'b1;
    run_until_state(S_REQ, 40, n);
    check("deny_req_reached", state_w, S_REQ);
    qif.qdeny = 1'b1;
    run_until_state(S_DEN, 10, n);
    check("deny_lat", n, 3);
    check("deny_qreqn", qif.qreqn, 1);
    check("deny_cnt_one", deny_cnt_w, 1);
    qif.qdeny = 1'b0;
    run_until_state(S_RUN, 10, n);
    check("deny_release_lat", n, 3);
    run_until_state(S_REQ, 40, n);
    check("deny_idle_restart", n, 17);

    // Wake pulse during REQUEST
    wake = 1'b1;
    tick();
    wake = 1'b0;
    qif.qacceptn = 1'b0;
    run_until_state(S_STOP, 10, n);
    check("wakereq_stopped", state_w, S_STOP);
    tick();
    check("wakereq_stop_1cyc", state_w, S_EXIT);
    qif.qacceptn = 1'b1;
    run_until_state(S_RUN, 10, n);
    check("wakereq_run", state_w, S_RUN);

    // Accept and deny together in REQUEST
    run_until_state(S_REQ, 40, n);
    qif.qacceptn = 1'b0; qif.qdeny = 1'b1;
    run_until_state(S_STOP, 10, n);
    check("both_to_stopped", state_w, S_STOP);
    check("both_proto_err", perr_w, 1);

    // Async reset while in EXIT
    qif.qdeny = 1'b0; en = 1'b0;
    tick();
    check("pre_rst_exit", state_w, S_EXIT);
    do_reset();

    // Deny pulse while running
    tick();
    qif.qacceptn = 1'b1;
    run_until_state(S_RUN, 10, n);
    qif.qdeny = 1'b1;
    tick();
    qif.qdeny = 1'b0;
    repeat (4) tick();
    check("run_deny_perr", perr_w, 1);
    check("run_deny_state", state_w, S_RUN);

    // Random traffic against the reactive device
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      allow_viol = (i >= 2000);
      device_react();
      if ($urandom_range(99) == 0) en = ~en;
      if ($urandom_range(149) == 0) sw_stop = ~sw_stop;
      wake = ($urandom_range(59) == 0);
      bus_active = ($urandom_range(29) == 0);
      if (allow_viol && $urandom_range(399) == 0 && qif.qreqn && qif.qacceptn && !qif.qdeny)
        qif.qdeny = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qchannel_ctrl.md
QCHANNEL_CTRL -- requirements
Module: qchannel_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 16, meaning the idle window in cycles before a quiesce request (legal range 1..255).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on qacceptn/qdeny (legal range 2..3).
REQ-003 The block SHALL have port wb_clk_i  input  1  single clock; all flops on its rising edge.
REQ-004 The block SHALL have port wb_rst_ni  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en_i  input  1  auto-quiesce enable.
REQ-006 The block SHALL have port sw_stop_i  input  1  software quiesce request (level).
REQ-007 The block SHALL have port wake_i  input  1  wake request (level), e.g. pending bus strobe.
REQ-008 The block SHALL have port bus_active_i  input  1  device activity; restarts the idle window.
REQ-009 The block SHALL have port qreqn  output  1  Q-Channel request, active-low, driven by a dedicated flop.
REQ-010 The block SHALL have port qacceptn  input  1  Q-Channel accept from the device, active-low.
REQ-011 The block SHALL have port qdeny  input  1  Q-Channel deny from the device.
REQ-012 The block SHALL have port clk_en_o  output  1  device clock-gate enable.
REQ-013 The block SHALL have port state_o  output  3  encoded FSM state.
REQ-014 The block SHALL have port deny_cnt_o  output  8  saturating denial count.
REQ-015 The block SHALL have port proto_err_o  output  1  sticky protocol-violation flag.

Function
REQ-016 qacceptn and qdeny SHALL each pass through SYNC_STAGES flops; the synchronizers reset to qacceptn_s=0 and qdeny_s=0. The FSM SHALL use only the synchronized values.
REQ-017 The FSM states SHALL be RUN=0, REQUEST=1, STOPPED=2, EXIT=3, DENIED=4; state_o SHALL equal the state register.
REQ-018 qreqn SHALL be 0 in REQUEST and STOPPED, and 1 in RUN, EXIT and DENIED; qreqn SHALL be updated on the same edge as the state.
REQ-019 clk_en_o SHALL be 0 only in STOPPED and 1 in all other states.
REQ-020 idle_cnt (8-bit, saturating at IDLE_CYCLES) SHALL behave as follows:
- in RUN: cleared when bus_active_i=1 or wake_i=1; otherwise incremented;
- in all other states: held at 0.
REQ-021 The RUN->REQUEST transition SHALL occur when idle_cnt==IDLE_CYCLES, bus_active_i=0, wake_i=0 and (sw_stop_i=1 or en_i=1).
REQ-022 The REQUEST state SHALL behave as follows:
- if qacceptn_s=0, go to STOPPED;
- else if qdeny_s=1, go to DENIED;
- there SHALL be no timeout and no withdrawal of qreqn.
REQ-023 REQUEST with qacceptn_s=0 and qdeny_s=1 simultaneously SHALL go to STOPPED and set proto_err_o.
REQ-024 wake_pend SHALL be set by wake_i=1 while in REQUEST and cleared on entry to EXIT.
REQ-025 STOPPED->EXIT SHALL occur when wake_i=1, or wake_pend=1, or (sw_stop_i=0 and en_i=0).
REQ-026 EXIT->RUN SHALL occur when qacceptn_s=1.
REQ-027 DENIED->RUN SHALL occur when qdeny_s=0. deny_cnt_o SHALL increment, saturating at 255, on entry to DENIED.
REQ-028 proto_err_o SHALL be set, and remain set until reset, on any of:
- qacceptn_s=0 or qdeny_s=1 in RUN;
- qdeny_s=1 in STOPPED or EXIT;
- qacceptn_s=0 in DENIED.
The FSM state SHALL be unaffected by these violations.
REQ-029 Latency with SYNC_STAGES=2 SHALL be: a device output change registered at edge M SHALL cause the FSM transition at edge M+3.

Reset
REQ-030 While wb_rst_ni=0, and immediately on its assertion, the block SHALL force:
- state=STOPPED;
- qreqn=0;
- clk_en_o=0;
- idle_cnt=0;
- wake_pend=0;
- deny_cnt_o=0;
- proto_err_o=0;
- synchronizers=0.
REQ-031 Reset asserted mid-handshake (REQUEST, EXIT or DENIED) SHALL abandon the handshake with no further qreqn toggle until reset is released.
REQ-032 After reset release, the wake from STOPPED SHALL follow REQ-025 with no additional delay.

Verification
REQ-033 Wake after reset: device model starts with qacceptn=0; release reset with en_i=0 and sw_stop_i=0. Required response: EXIT with qreqn=1 and clk_en_o=1 on the first edge; RUN 3 edges after the device raises qacceptn.
REQ-034 Auto quiesce: en_i=1 and bus_active_i last sampled 1 at edge N. Required response: qreqn=0 (REQUEST) at edge N+17; device accepts; clk_en_o=0 three edges after qacceptn falls.
REQ-035 Deny: device asserts qdeny in REQUEST. Required response:
- DENIED with qreqn=1 and deny_cnt_o=1;
- RUN after qdeny drops;
- idle window restarts from 0.
REQ-036 Wake during REQUEST: pulse wake_i for 1 cycle while in REQUEST; device then accepts. Required response: STOPPED for exactly 1 cycle, then EXIT, then RUN.
REQ-037 Protocol violations:
- qacceptn=0 together with qdeny=1 in REQUEST: required response is STOPPED and proto_err_o=1;
- qdeny=1 in RUN: required response is proto_err_o=1 with state unchanged.
REQ-038 Async reset in EXIT: required response is qreqn=0, clk_en_o=0 and state_o=2 without waiting for a clock edge.
